// File: rtl/axis_uart_pkg.sv
// Shared constants, FSM state encoding and bit-timing helpers for the AXIS/UART bridge.
package axis_uart_pkg;
  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Widest value ever loaded is CLKS_PER_BIT-1.
  function automatic int calc_cnt_width(input int clk_hz, input int baud);
    return $clog2(clk_hz / baud);
  endfunction
endpackage

// File: rtl/axis_uart_bit_timer.sv
// Loadable down-counter; tick is high while the count rests at zero.
module axis_uart_bit_timer #(
  parameter int W = 5
) (
  input  logic         aclk,
  input  logic         arstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);
endmodule

// File: rtl/axis_uart.sv
// AXI-Stream to UART bridge: independent TX serialiser and RX deserialiser on one clock.
// state     | meaning
// ST_IDLE   | TX: ready for a word, line high / RX: waiting for a falling edge
// ST_START  | start bit (RX: waiting for the mid-bit resample)
// ST_DATA   | data bits, LSB first
// ST_PARITY | optional parity bit
// ST_STOP   | stop bit(s)
module axis_uart
  import axis_uart_pkg::*;
#(
  parameter int baud_clock_speed = 50000000,
  parameter int baud_rate        = 115200,
  parameter int parity_ena       = 0,
  parameter int parity_type      = 0,
  parameter int stop_bits        = 1,
  parameter int data_bits        = 8,
  parameter int rx_delay         = 0
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic [data_bits-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [data_bits-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 tx,
  input  logic                 rx
);
  localparam int CLKS_PER_BIT = calc_clks_per_bit(baud_clock_speed, baud_rate);
  localparam int CW           = calc_cnt_width(baud_clock_speed, baud_rate);
  localparam logic [CW-1:0] BIT_LOAD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] START_LOAD = CW'(CLKS_PER_BIT / 2 + rx_delay - 1);
  localparam logic [3:0] LAST_DATA = 4'(data_bits - 1);
  localparam logic [3:0] LAST_STOP = 4'(stop_bits - 1);
  localparam logic PAR_INV = (parity_type == PARITY_ODD);
  localparam logic HAS_PAR = (parity_ena != 0);

  // ---------------- TX ----------------
  uart_state_e          tx_state, tx_state_d;
  logic [data_bits-1:0] tx_shreg, tx_shreg_d;
  logic [3:0]           tx_bits, tx_bits_d;
  logic                 tx_par, tx_par_d, tx_load, tx_tick, rst_done;

  axis_uart_bit_timer #(.W(CW)) u_tx_timer (
    .aclk(aclk), .arstn(arstn), .load(tx_load), .load_val(BIT_LOAD), .tick(tx_tick)
  );

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      tx_state <= ST_IDLE;
      tx_shreg <= '0;
      tx_bits  <= '0;
      tx_par   <= 1'b0;
      rst_done <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tx_shreg <= tx_shreg_d;
      tx_bits  <= tx_bits_d;
      tx_par   <= tx_par_d;
      rst_done <= 1'b1;
    end
  end

  // rst_done keeps tready low for the first cycle after reset release.
  assign s_axis_tready = (tx_state == ST_IDLE) && rst_done;

  always_comb begin
    tx_state_d = tx_state;
    tx_shreg_d = tx_shreg;
    tx_bits_d  = tx_bits;
    tx_par_d   = tx_par;
    tx_load    = 1'b0;
    tx         = 1'b1;
    case (tx_state)
      ST_IDLE: begin
        if (s_axis_tvalid && s_axis_tready) begin
          tx_state_d = ST_START;
          tx_shreg_d = s_axis_tdata;
          tx_par_d   = (^s_axis_tdata) ^ PAR_INV;
          tx_load    = 1'b1;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (tx_tick) begin
          tx_state_d = ST_DATA;
          tx_bits_d  = '0;
          tx_load    = 1'b1;
        end
      end
      ST_DATA: begin
        tx = tx_shreg[0];
        if (tx_tick) begin
          tx_load    = 1'b1;
          tx_shreg_d = tx_shreg >> 1;
          tx_bits_d  = tx_bits + 4'd1;
          if (tx_bits == LAST_DATA) begin
            tx_bits_d  = '0;
            tx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        tx = tx_par;
        if (tx_tick) begin
          tx_state_d = ST_STOP;
          tx_bits_d  = '0;
          tx_load    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_tick) begin
          if (tx_bits == LAST_STOP) begin
            tx_state_d = ST_IDLE;
          end else begin
            tx_bits_d = tx_bits + 4'd1;
            tx_load   = 1'b1;
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  uart_state_e          rx_state, rx_state_d;
  logic [data_bits-1:0] rx_shreg, rx_shreg_d;
  logic [3:0]           rx_bits, rx_bits_d;
  logic [1:0]           rx_sync;
  logic                 rx_s, rx_prev, rx_load, rx_tick, rx_done, rx_done_d;
  logic [CW-1:0]        rx_load_val;

  assign rx_s = rx_sync[1];

  axis_uart_bit_timer #(.W(CW)) u_rx_timer (
    .aclk(aclk), .arstn(arstn), .load(rx_load), .load_val(rx_load_val), .tick(rx_tick)
  );

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_shreg <= '0;
      rx_bits  <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      rx_prev  <= rx_s;
      rx_state <= rx_state_d;
      rx_shreg <= rx_shreg_d;
      rx_bits  <= rx_bits_d;
      rx_done  <= rx_done_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state;
    rx_shreg_d  = rx_shreg;
    rx_bits_d   = rx_bits;
    rx_load     = 1'b0;
    rx_load_val = BIT_LOAD;
    rx_done_d   = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_d  = ST_START;
          rx_load     = 1'b1;
          rx_load_val = START_LOAD;
        end
      end
      ST_START: begin
        if (rx_tick) begin
          rx_state_d = rx_s ? ST_IDLE : ST_DATA;
          rx_bits_d  = '0;
          rx_load    = !rx_s;
        end
      end
      ST_DATA: begin
        if (rx_tick) begin
          rx_load    = 1'b1;
          rx_shreg_d = {rx_s, rx_shreg[data_bits-1:1]};
          rx_bits_d  = rx_bits + 4'd1;
          if (rx_bits == LAST_DATA) begin
            rx_bits_d  = '0;
            rx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (rx_tick) begin
          if (((^rx_shreg) ^ PAR_INV) != rx_s) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_STOP;
            rx_load    = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (rx_tick) begin
          if (!rx_s) begin
            rx_state_d = ST_IDLE;
          end else if (rx_bits == LAST_STOP) begin
            rx_state_d = ST_IDLE;
            rx_done_d  = 1'b1;
          end else begin
            rx_bits_d = rx_bits + 4'd1;
            rx_load   = 1'b1;
          end
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // A word arriving while the held one is stalled is dropped.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (rx_done && (!m_axis_tvalid || m_axis_tready)) begin
      m_axis_tdata  <= rx_shreg;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis_uart.sv
// Directed bench for axis_uart: 8N1 loopback/injection instance plus even/odd parity instances.
module tb_axis_uart;
  import axis_uart_pkg::*;

  logic       tb_data_clk = 1'b0;
  logic       arstn;
  logic [7:0] s_tdata, m_tdata, s_tdata_p, m_tdata_pe, m_tdata_po;
  logic       s_tvalid, s_tready, m_tvalid, m_tready, tx8, rx8, loop_en, rx_drv;
  logic       s_tvalid_p, s_tready_pe, s_tready_po, m_tvalid_pe, m_tvalid_po;
  logic       tx_pe, tx_po, rx_drv_p;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$], rx_q[$], rx_pq[$], rx_oq[$];

  always #10 tb_data_clk = ~tb_data_clk;

  assign rx8 = loop_en ? tx8 : rx_drv;

  axis_uart #(.baud_clock_speed(50000000), .baud_rate(2000000)) u_8n1 (
    .aclk(tb_data_clk), .arstn(arstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .tx(tx8), .rx(rx8)
  );

  axis_uart #(.baud_clock_speed(50000000), .baud_rate(2000000),
              .parity_ena(1), .parity_type(PARITY_EVEN)) u_pe (
    .aclk(tb_data_clk), .arstn(arstn),
    .s_axis_tdata(s_tdata_p), .s_axis_tvalid(s_tvalid_p), .s_axis_tready(s_tready_pe),
    .m_axis_tdata(m_tdata_pe), .m_axis_tvalid(m_tvalid_pe), .m_axis_tready(1'b1),
    .tx(tx_pe), .rx(rx_drv_p)
  );

  axis_uart #(.baud_clock_speed(50000000), .baud_rate(2000000),
              .parity_ena(1), .parity_type(PARITY_ODD)) u_po (
    .aclk(tb_data_clk), .arstn(arstn),
    .s_axis_tdata(s_tdata_p), .s_axis_tvalid(s_tvalid_p), .s_axis_tready(s_tready_po),
    .m_axis_tdata(m_tdata_po), .m_axis_tvalid(m_tvalid_po), .m_axis_tready(1'b1),
    .tx(tx_po), .rx(tx_po)
  );

  // Inputs change 2 units after posedge, so beats are captured on the negedge.
  always @(negedge tb_data_clk) begin
    if (m_tvalid && m_tready) rx_q.push_back(m_tdata);
    if (m_tvalid_pe) rx_pq.push_back(m_tdata_pe);
    if (m_tvalid_po) rx_oq.push_back(m_tdata_po);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no end, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge tb_data_clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drives 11 bit periods (LSB first) on the selected rx line, then idles it high.
  task automatic send_bits(input int sel, input logic [10:0] bits);
    for (int i = 0; i < 11; i++) begin
      if (sel == 0) rx_drv = bits[i];
      else          rx_drv_p = bits[i];
      repeat (25) step();
    end
    if (sel == 0) rx_drv = 1'b1;
    else          rx_drv_p = 1'b1;
  endtask

  task automatic expect_rx(input string tag, input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check({tag, "_count"}, rx_q.size(), n);
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check(tag, rx_q.pop_front(), exp_q.pop_front());
  endtask

  initial begin
    logic [9:0]  frame;
    logic [24:0] samp;
    logic        busy;
    int          n, c;
    int          hs[3];

    arstn = 1'b0; loop_en = 1'b1; rx_drv = 1'b1; rx_drv_p = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1; s_tdata_p = '0; s_tvalid_p = 1'b0;
    repeat (3) step();
    check("rst_tx", tx8, 1);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    arstn = 1'b1;
    #1;
    check("release_tready_low", s_tready, 0);
    step();
    check("release_tready_high", s_tready, 1);

    // TX waveform for 0x41 (looped back into RX as well)
    s_tdata = 8'h41; s_tvalid = 1'b1; exp_q.push_back(8'h41);
    step();
    s_tvalid = 1'b0;
    busy  = 1'b0;
    frame = {1'b1, 8'h41, 1'b0};
    for (int b = 0; b < 10; b++) begin
      samp = '0;
      for (int k = 0; k < 25; k++) begin
        samp[k] = tx8;
        busy = busy | s_tready;
        step();
      end
      check($sformatf("tx_bit%0d", b), samp, frame[b] ? 25'h1ffffff : 25'h0);
    end
    check("tx_tready_busy", busy, 0);
    check("tx_tready_idle", s_tready, 1);
    check("tx_line_idle", tx8, 1);

    // Back-to-back streaming in loopback
    s_tdata = 8'h42; s_tvalid = 1'b1; n = 0; c = 0;
    while (n < 3 && c < 2000) begin
      if (s_tready) begin
        exp_q.push_back(s_tdata);
        hs[n] = c;
        n++;
        step(); c++;
        s_tdata = s_tdata + 8'd1;
      end else begin
        step(); c++;
      end
    end
    s_tvalid = 1'b0;
    check("stream_handshakes", n, 3);
    check("stream_gap01", hs[1] - hs[0], 251);
    check("stream_gap12", hs[2] - hs[1], 251);
    expect_rx("loopback", 4, 1500);

    // Parity bit on TX: 0x41 has even weight
    s_tdata_p = 8'h41; s_tvalid_p = 1'b1;
    step();
    s_tvalid_p = 1'b0;
    repeat (237) step();
    check("par_even_bit", tx_pe, 0);
    check("par_odd_bit", tx_po, 1);
    repeat (25) step();
    check("par_even_stop", tx_pe, 1);
    check("par_even_busy", s_tready_pe, 0);
    check("par_odd_busy", s_tready_po, 0);
    c = 0;
    while (rx_oq.size() < 1 && c < 200) begin step(); c++; end
    check("par_odd_loop_count", rx_oq.size(), 1);
    if (rx_oq.size() > 0) check("par_odd_loop_data", rx_oq.pop_front(), 8'h41);

    // Parity check on RX: wrong then right parity for 0x41, even
    send_bits(1, {1'b1, 1'b1, 8'h41, 1'b0});
    repeat (20) step();
    check("par_bad_dropped", rx_pq.size(), 0);
    send_bits(1, {1'b1, 1'b0, 8'h41, 1'b0});
    c = 0;
    while (rx_pq.size() < 1 && c < 100) begin step(); c++; end
    check("par_good_count", rx_pq.size(), 1);
    if (rx_pq.size() > 0) check("par_good_data", rx_pq.pop_front(), 8'h41);

    // Backpressure/overrun on injected frames
    loop_en = 1'b0; m_tready = 1'b0;
    send_bits(0, {2'b11, 8'h10, 1'b0});
    exp_q.push_back(8'h10);
    repeat (10) step();
    check("bp_valid_first", m_tvalid, 1);
    check("bp_data_first", m_tdata, 8'h10);
    send_bits(0, {2'b11, 8'h20, 1'b0});
    repeat (10) step();
    check("bp_valid_held", m_tvalid, 1);
    check("bp_data_held", m_tdata, 8'h10);
    check("bp_no_beat", rx_q.size(), 0);
    m_tready = 1'b1;
    step();
    step();
    check("bp_valid_cleared", m_tvalid, 0);
    repeat (20) step();
    expect_rx("bp_single_beat", 1, 10);

    // Glitch, framing error, then a good frame
    rx_drv = 1'b0;
    repeat (5) step();
    rx_drv = 1'b1;
    repeat (60) step();
    check("glitch_ignored", rx_q.size(), 0);
    send_bits(0, {2'b10, 8'h77, 1'b0});
    repeat (30) step();
    check("stop_err_dropped", rx_q.size(), 0);
    send_bits(0, {2'b11, 8'h5a, 1'b0});
    exp_q.push_back(8'h5a);
    expect_rx("good_5a", 1, 50);

    // Reset during TX data bit 3 of 0xA5 (that bit is 0)
    s_tdata = 8'hA5; s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    repeat (4 * 25 + 10) step();
    check("pre_rst_tx_bit3", tx8, 0);
    arstn = 1'b0;
    #1;
    check("mid_rst_tx", tx8, 1);
    check("mid_rst_tready", s_tready, 0);
    repeat (3) step();
    check("hold_rst_tx", tx8, 1);
    check("hold_rst_tready", s_tready, 0);
    arstn = 1'b1;
    #1;
    check("post_rst_tready_low", s_tready, 0);
    step();
    check("post_rst_tready_high", s_tready, 1);
    loop_en = 1'b1;
    s_tdata = 8'h3C; s_tvalid = 1'b1; exp_q.push_back(8'h3C);
    step();
    s_tvalid = 1'b0;
    check("post_rst_start_bit", tx8, 0);
    expect_rx("post_rst_loop", 1, 400);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
